// File: rtl/pipe_pkg.sv
// pipe_pkg: shared sequencer state, register and control-field constants
// for the 5-stage core.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        ERR      = 2'd3
    } hazard_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int WB_W  = 2;
    localparam int MEM_W = 2;
    localparam int EX_W  = 4;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_ADVANCE = 5'b11000;
    localparam hz_ctrl_t CTRL_FLUSH   = 5'b11100;
    localparam hz_ctrl_t CTRL_STALL   = 5'b00010;
    localparam hz_ctrl_t CTRL_FREEZE  = 5'b00001;
    localparam hz_ctrl_t CTRL_RESET   = 5'b00010;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between the load in EX
// and the operands of the instruction in ID; shared with forwarding.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rt_addr,
    input  logic [4:0] i_id_rs_addr,
    input  logic [4:0] i_id_rt_addr,
    input  logic       i_id_uses_rt,
    output logic       o_lu
);

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_dst_live;

    assign w_rs_hit   = (i_ex_rt_addr == i_id_rs_addr);
    assign w_rt_hit   = i_id_uses_rt && (i_ex_rt_addr == i_id_rt_addr);
    // $zero is never really written, so a load into it can't create a hazard
    assign w_dst_live = (i_ex_rt_addr != REG_ZERO);
    assign o_lu       = i_ex_memread && w_dst_live && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: PC / IF/ID / ID/EX sequencer for load-use, branch and
// data-memory waits. HAZARD_CTRL_PERF_EN adds stall/flush counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 255
)
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [4:0] id_rs_addr_i,
    input  logic [4:0] id_rt_addr_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rt_addr_i,
    input  logic       branch_taken_i,
    input  logic       mem_busy_i,
    output logic       pc_write_o,
    output logic       ifid_write_o,
    output logic       ifid_flush_o,
    output logic       idex_bubble_o,
    output logic       pipe_hold_o,
    output logic       timeout_o
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);
    localparam logic [7:0] TMO    = 8'(MEM_TIMEOUT);

    hazard_state_t r_state;
    hazard_state_t w_state_nxt;
    logic [2:0]    r_stall_cnt;
    logic [2:0]    w_stall_nxt;
    logic [7:0]    r_wait_cnt;
    logic [7:0]    w_wait_nxt;

    hazard_state_t w_run_state;
    logic [2:0]    w_run_stall;
    logic [7:0]    w_run_wait;
    hz_ctrl_t      w_run_ctrl;
    hz_ctrl_t      w_ctrl;
    hz_ctrl_t      w_out;
    logic          w_lu;

    hazard_detect u_detect (
        .i_ex_memread (ex_memread_i),
        .i_ex_rt_addr (ex_rt_addr_i),
        .i_id_rs_addr (id_rs_addr_i),
        .i_id_rt_addr (id_rt_addr_i),
        .i_id_uses_rt (id_uses_rt_i),
        .o_lu         (w_lu)
    );

    // Decision taken from a free-running pipeline; reused when a memory
    // wait ends so the releasing cycle is not lost.
    always_comb begin
        w_run_state = RUN;
        w_run_stall = 3'd0;
        w_run_wait  = 8'd0;
        w_run_ctrl  = CTRL_ADVANCE;
        if (mem_busy_i) begin
            w_run_ctrl  = CTRL_FREEZE;
            w_run_state = MEM_WAIT;
            w_run_wait  = 8'd1;
        end else if (w_lu) begin
            w_run_ctrl = CTRL_STALL;
            if (LOAD_LAT > 1) begin
                w_run_state = LU_STALL;
                w_run_stall = LAT_M1;
            end
        end else if (branch_taken_i) begin
            w_run_ctrl = CTRL_FLUSH;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall_nxt = r_stall_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_ctrl      = CTRL_ADVANCE;
        unique case (r_state)
            RUN: begin
                w_ctrl      = w_run_ctrl;
                w_state_nxt = w_run_state;
                w_stall_nxt = w_run_stall;
                w_wait_nxt  = w_run_wait;
            end
            LU_STALL: begin
                if (mem_busy_i) begin
                    w_ctrl      = CTRL_FREEZE;
                    w_state_nxt = MEM_WAIT;
                    w_stall_nxt = 3'd0;
                    w_wait_nxt  = 8'd1;
                end else begin
                    w_ctrl = CTRL_STALL;
                    if (r_stall_cnt <= 3'd1) begin
                        w_state_nxt = RUN;
                        w_stall_nxt = 3'd0;
                    end else begin
                        w_stall_nxt = r_stall_cnt - 3'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_busy_i) begin
                    w_ctrl = CTRL_FREEZE;
                    if (r_wait_cnt >= TMO) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_wait_nxt = sat_inc8(r_wait_cnt);
                    end
                end else begin
                    w_ctrl      = w_run_ctrl;
                    w_state_nxt = w_run_state;
                    w_stall_nxt = w_run_stall;
                    w_wait_nxt  = w_run_wait;
                end
            end
            ERR: begin
                w_ctrl = CTRL_FREEZE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= RUN;
            r_stall_cnt <= 3'd0;
            r_wait_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_wait_cnt  <= w_wait_nxt;
        end
    end

    // Reset is applied combinationally so outputs settle before any edge.
    assign w_out         = rst_n_i ? w_ctrl : CTRL_RESET;
    assign pc_write_o    = w_out.pc_write;
    assign ifid_write_o  = w_out.ifid_write;
    assign ifid_flush_o  = w_out.ifid_flush;
    assign idex_bubble_o = w_out.idex_bubble;
    assign pipe_hold_o   = w_out.pipe_hold;
    assign timeout_o     = (r_state == ERR);

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] r_stall_perf;
    logic [31:0] r_flush_perf;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_perf <= 32'd0;
            r_flush_perf <= 32'd0;
        end else begin
            if (!pc_write_o && (r_stall_perf != 32'hFFFF_FFFF)) begin
                r_stall_perf <= r_stall_perf + 32'd1;
            end
            if (ifid_flush_o && (r_flush_perf != 32'hFFFF_FFFF)) begin
                r_flush_perf <= r_flush_perf + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_perf;
    assign flush_cnt_o = r_flush_perf;
`endif

endmodule
